equalizer_coeff_ctrl: RTL
=========================

// Module: equalizer_coeff_ctrl
// PURPOSE
// - Owns the biquad coefficient store of the equalizer: two banks (active/shadow) of
//   NR_CHANNELS*NR_EQ_BANDS*5 coefficients (a0,a1,a2,b1,b2 per band).
// - Host writes the shadow bank; the equalizer reads the active bank.
// - On commit, banks swap only between samples. The controller gates the equalizer's
//   sample handshake so no sample ever mixes the two coefficient sets.
// - Optionally copies the new active bank back into the shadow, so that incremental
//   edits start from the current set.
// PARAMETERS
// - NR_CHANNELS     4   audio channels, same value as the equalizer
// - NR_EQ_BANDS     8   biquad bands per channel, same value as the equalizer
// - EQ_COEFF_WIDTH  32  coefficient word width
// - Derived: NR_EQ_COEFF=NR_CHANNELS*NR_EQ_BANDS*5 (default 160); ADDR_WIDTH=clog2(NR_EQ_COEFF) (default 8)
// PORTS
// - clk              in   1               single clock
// - rst              in   1               synchronous reset, active-high
// - cfg_tdata        in   EQ_COEFF_WIDTH  coefficient to write to the shadow bank
// - cfg_taddr        in   ADDR_WIDTH      coefficient index
// - cfg_tvalid       in   1               write request
// - cfg_tready       out  1               write accepted when cfg_tvalid && cfg_tready
// - cfg_commit       in   1               1-cycle pulse: request bank swap
// - cfg_copy         in   1               sampled with cfg_commit: copy active->shadow after swap
// - cfg_done         out  1               1-cycle pulse when swap (and copy, if requested) completes
// - cfg_err          out  1               1-cycle pulse: accepted write had cfg_taddr>=NR_EQ_COEFF
// - active_bank      out  1               currently active bank index
// - s_tvalid         in   1               upstream sample valid (tdata/tid bypass this block)
// - s_tready         out  1               = eq_s_tready && !hold
// - eq_s_tvalid      out  1               = s_tvalid && !hold
// - eq_s_tready      in   1               equalizer s_tready; high = idle between samples
// - eq_coeff_addr    in   ADDR_WIDTH      equalizer coefficient address
// - eq_coeff         out  EQ_COEFF_WIDTH  bank[active_bank][eq_coeff_addr], combinational read (0 if addr out of range)
// BEHAVIOUR
// - Reset: state=IDLE, active_bank=0, cfg_tready=1, cfg_done=0, cfg_err=0, hold=0,
//   pending commit cleared, copy aborted. RAM contents are kept (power-up 0).
// - FSM states: IDLE, WAIT_IDLE, SWAP, COPY.
// - IDLE: cfg_tready=1, hold=0. A write lands in shadow[cfg_taddr] at the next edge.
//   cfg_commit -> WAIT_IDLE; cfg_copy is latched. A write and a commit in the same cycle:
//   the write is applied first and is included in the swap.
// - WAIT_IDLE: cfg_tready=0. hold=1 from this state onward (combinational on state),
//   so no new sample is started. When eq_s_tready=1 -> SWAP.
// - SWAP (1 cycle): active_bank toggles at the clock edge ending SWAP.
//   Then -> COPY if copy was latched; otherwise pulse cfg_done and -> IDLE.
// - COPY: one word per cycle, shadow[k] <= active[k] for k=0..NR_EQ_COEFF-1
//   (NR_EQ_COEFF cycles). hold=0 and samples flow normally. cfg_tready=0.
//   After the last word: pulse cfg_done, -> IDLE.
// - cfg_commit outside IDLE is ignored; the host must wait for cfg_done.
// - Out-of-range write: handshake completes, no RAM write, cfg_err pulses the next cycle.
// - A sample already in flight at commit time finishes entirely on the old bank. The
//   first sample accepted after SWAP uses only the new bank.
// - Commit to done latency: WAIT_IDLE duration + 1 (+ NR_EQ_COEFF with copy).
// - eq_coeff has zero-cycle latency relative to eq_coeff_addr. The equalizer samples it
//   in the cycle the address is presented.
// STRUCTURE
// - Package eq_pkg: NR_EQ_BAND_COEFF=5, clog2 function, NR_EQ_COEFF/ADDR_WIDTH derivation,
//   FSM state encodings.
// - Sub-module eq_coeff_bank_ram: 2*NR_EQ_COEFF words, 1 write port, 2 async read ports
//   (equalizer and copy source).
// - Top level holds the FSM, the copy counter and the handshake gating.
// TESTING
// - Reset, write shadow[0]=0x4000_0000, commit without copy, eq_coeff_addr=0
//   -> eq_coeff=0x4000_0000, active_bank=1, cfg_done 1 pulse.
// - Commit while eq_s_tready=0 for 50 cycles -> s_tready=0 throughout, swap 1 cycle
//   after eq_s_tready rises, the in-flight sample's addresses 0..39 all return old values.
// - Commit with cfg_copy=1 -> cfg_done exactly 161 cycles after SWAP,
//   shadow[k]==active[k] for all 160 k, samples accepted during COPY.
// - Write cfg_taddr=160 -> cfg_tready handshake completes, cfg_err pulses once, no bank word changes.
// - Assert rst in the middle of COPY at k=80 -> IDLE, cfg_tready=1, active_bank=0,
//   no cfg_done pulse, next commit works.
// - Write and commit in the same cycle, then 2nd commit during WAIT_IDLE -> the write is
//   visible after the swap, the 2nd commit is ignored, exactly one cfg_done.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared constants, sizing helpers and FSM encoding for the equalizer coefficient controller.
package eq_pkg;

    // a0, a1, a2, b1, b2 per biquad band
    localparam int unsigned NR_EQ_BAND_COEFF = 5;

    // Smallest width able to index 'value' entries (at least 1 bit).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int unsigned nr_eq_coeff(input int unsigned nr_channels,
                                                 input int unsigned nr_bands);
        return nr_channels * nr_bands * NR_EQ_BAND_COEFF;
    endfunction

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitIdle = 2'd1,
        StSwap     = 2'd2,
        StCopy     = 2'd3
    } eq_state_e;

endpackage

// File: rtl/eq_coeff_bank_ram.sv
// Two-bank coefficient store: one synchronous write port, two asynchronous read ports
// (equalizer read and copy source). Out-of-range reads return zero, writes are dropped.
module eq_coeff_bank_ram #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 160,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  eq_bank,
    input  logic [ADDR_WIDTH-1:0] eq_addr,
    output logic [WIDTH-1:0]      eq_data,
    input  logic                  cp_bank,
    input  logic [ADDR_WIDTH-1:0] cp_addr,
    output logic [WIDTH-1:0]      cp_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] mem [2][DEPTH];

    // Write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    // Asynchronous read ports, zero outside the coefficient range.
    always_comb begin
        eq_data = '0;
        cp_data = '0;
        if (eq_addr <= LAST_ADDR) begin
            eq_data = mem[eq_bank][eq_addr];
        end
        if (cp_addr <= LAST_ADDR) begin
            cp_data = mem[cp_bank][cp_addr];
        end
    end

endmodule

// File: rtl/equalizer_coeff_ctrl.sv
// Active/shadow coefficient bank controller. The host fills the shadow bank, a commit swaps
// banks between samples by holding off the equalizer's sample handshake, and an optional
// copy afterwards refreshes the shadow from the new active bank.
module equalizer_coeff_ctrl
    import eq_pkg::*;
#(
    parameter int unsigned NR_CHANNELS    = 4,
    parameter int unsigned NR_EQ_BANDS    = 8,
    parameter int unsigned EQ_COEFF_WIDTH = 32,
    localparam int unsigned NR_EQ_COEFF   = nr_eq_coeff(NR_CHANNELS, NR_EQ_BANDS),
    localparam int unsigned ADDR_WIDTH    = clog2(NR_EQ_COEFF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EQ_COEFF_WIDTH-1:0] cfg_tdata,
    input  logic [ADDR_WIDTH-1:0]     cfg_taddr,
    input  logic                      cfg_tvalid,
    output logic                      cfg_tready,
    input  logic                      cfg_commit,
    input  logic                      cfg_copy,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic                      active_bank,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic                      eq_s_tvalid,
    input  logic                      eq_s_tready,
    input  logic [ADDR_WIDTH-1:0]     eq_coeff_addr,
    output logic [EQ_COEFF_WIDTH-1:0] eq_coeff
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NR_EQ_COEFF - 1);

    eq_state_e               state_q, state_d;
    logic                    active_bank_q;
    logic                    copy_q;
    logic [ADDR_WIDTH-1:0]   copy_cnt_q;
    logic                    done_q, done_d;
    logic                    err_q;
    logic                    hold;
    logic                    in_range;
    logic                    ram_wr_en;
    logic [ADDR_WIDTH-1:0]   ram_wr_addr;
    logic [EQ_COEFF_WIDTH-1:0] ram_wr_data;
    logic [EQ_COEFF_WIDTH-1:0] copy_rd_data;

    assign in_range    = (cfg_taddr <= LAST_IDX);
    assign s_tready    = eq_s_tready && !hold;
    assign eq_s_tvalid = s_tvalid && !hold;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign active_bank = active_bank_q;

    // Next-state, host handshake, sample gating and RAM write mux.
    always_comb begin
        state_d     = state_q;
        cfg_tready  = 1'b0;
        hold        = 1'b0;
        done_d      = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = cfg_taddr;
        ram_wr_data = cfg_tdata;
        case (state_q)
            StIdle: begin
                cfg_tready = 1'b1;
                // A write alongside a commit still lands before the swap.
                ram_wr_en  = cfg_tvalid && in_range;
                if (cfg_commit) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                hold = 1'b1;
                if (eq_s_tready) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                // Held here too: the bank only flips at the edge ending this cycle.
                hold = 1'b1;
                if (copy_q) begin
                    state_d = StCopy;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StCopy: begin
                ram_wr_en   = 1'b1;
                ram_wr_addr = copy_cnt_q;
                ram_wr_data = copy_rd_data;
                if (copy_cnt_q == LAST_IDX) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, bank select, copy bookkeeping and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            active_bank_q <= 1'b0;
            copy_q        <= 1'b0;
            copy_cnt_q    <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= cfg_tvalid && cfg_tready && !in_range;
            if (state_q == StIdle && cfg_commit) begin
                copy_q <= cfg_copy;
            end
            if (state_q == StSwap) begin
                active_bank_q <= ~active_bank_q;
            end
            if (state_q == StCopy) begin
                copy_cnt_q <= copy_cnt_q + ADDR_WIDTH'(1);
            end else begin
                copy_cnt_q <= '0;
            end
        end
    end

    // Host writes and the copy both target the shadow bank; the copy reads the active one.
    eq_coeff_bank_ram #(
        .WIDTH      (EQ_COEFF_WIDTH),
        .DEPTH      (NR_EQ_COEFF),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_bank (~active_bank_q),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .eq_bank (active_bank_q),
        .eq_addr (eq_coeff_addr),
        .eq_data (eq_coeff),
        .cp_bank (active_bank_q),
        .cp_addr (copy_cnt_q),
        .cp_data (copy_rd_data)
    );

endmodule
